keypad_matrix_emu: RTL and testbench

KEYPAD_MATRIX_EMU -- requirements
Module: keypad_matrix_emu

---
 rtl/keypad_matrix_emu.sv | 236 +++++++++++++++++++++++
 tb/tb_keypad_matrix_emu.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_matrix_emu.sv
// keypad_matrix_emu: emulates one key of a 3x3 active-low scanned keypad matrix.
// A press command (key, hold length) plays out as contact bounce in, a clean
// hold, and contact bounce out; the row lines answer the scanner's column drive
// combinationally from the current contact state and the latched key.
//
// Build option: define KPAD_EMU_BOUNCE_EN to include the two bounce phases.
// Without it a press is a clean hold only.
//
// Command handshake: a command transfers on a rising edge where press_valid
// and press_ready are both 1; press_ready is 1 exactly while the FSM is IDLE,
// and the command inputs need only be stable for that one edge.
module keypad_matrix_emu #(
  parameter int BOUNCE_CYCLES = 16,
  parameter int BOUNCE_TOGGLE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  column,
  output logic [2:0]  row,
  input  logic        press_valid,
  output logic        press_ready,
  input  logic [3:0]  press_key,
  input  logic [15:0] press_hold,
  input  logic        press_abort,
  output logic        contact,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  state_dbg
);

  // Reject parameter values outside the supported range at elaboration.
  if (BOUNCE_CYCLES < 2 || BOUNCE_CYCLES > 255 ||
      BOUNCE_TOGGLE < 1 || BOUNCE_TOGGLE > BOUNCE_CYCLES) begin : g_param_check
    $error("keypad_matrix_emu: BOUNCE_CYCLES/BOUNCE_TOGGLE out of range");
  end

`ifdef KPAD_EMU_BOUNCE_EN
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    BOUNCE_IN  = 2'd1,
    HELD       = 2'd2,
    BOUNCE_OUT = 2'd3
  } state_t;

  // Last index of a bounce phase and of a toggle interval.
  localparam logic [7:0] LAST_PHASE  = 8'(BOUNCE_CYCLES - 1);
  localparam logic [7:0] LAST_TOGGLE = 8'(BOUNCE_TOGGLE - 1);

  logic [7:0] phase_cnt;
  logic [7:0] tog_cnt;
  logic       phase_end;
  logic       tog_end;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd2
  } state_t;
`endif

  state_t      state;
  logic [15:0] hold_cnt;
  logic [15:0] hold_len;
  logic [1:0]  key_r;
  logic [1:0]  key_c;
  logic [3:0]  key_rc;
  logic        key_ok;
  logic        hold_end;
  logic        col_low;

  assign press_ready = (state == IDLE);
  assign busy        = (state != IDLE);
  assign state_dbg   = state;

  // Split the offered key code into {row, column}; codes 9..15 are invalid.
  always_comb begin
    key_rc = 4'b1111;
    key_ok = 1'b1;
    case (press_key)
      4'd0:    key_rc = 4'b00_00;
      4'd1:    key_rc = 4'b00_01;
      4'd2:    key_rc = 4'b00_10;
      4'd3:    key_rc = 4'b01_00;
      4'd4:    key_rc = 4'b01_01;
      4'd5:    key_rc = 4'b01_10;
      4'd6:    key_rc = 4'b10_00;
      4'd7:    key_rc = 4'b10_01;
      4'd8:    key_rc = 4'b10_10;
      default: key_ok = 1'b0;
    endcase
  end

  // End-of-interval flags for the hold and bounce counters.
  always_comb begin
    hold_end = (hold_cnt == hold_len - 16'd1);
`ifdef KPAD_EMU_BOUNCE_EN
    phase_end = (phase_cnt == LAST_PHASE);
    tog_end   = (tog_cnt == LAST_TOGGLE);
`endif
  end

  // Row sense: only the latched key's row can be pulled low, and only while
  // the contact is closed and that key's own column is driven. Other driven
  // columns are ignored, so multi-column drive cannot create ghost rows.
  always_comb begin
    row     = 3'b111;
    col_low = 1'b0;
    case (key_c)
      2'd0:    col_low = ~column[0];
      2'd1:    col_low = ~column[1];
      2'd2:    col_low = ~column[2];
      default: col_low = 1'b0;
    endcase
    if (contact && col_low) begin
      case (key_r)
        2'd0:    row[0] = 1'b0;
        2'd1:    row[1] = 1'b0;
        2'd2:    row[2] = 1'b0;
        default: row    = 3'b111;
      endcase
    end
  end

  // Press sequencer: accepts commands, steps through the press phases and
  // drives the registered contact, done and err outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      contact  <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      hold_cnt <= 16'd0;
      hold_len <= 16'd0;
      key_r    <= 2'd0;
      key_c    <= 2'd0;
`ifdef KPAD_EMU_BOUNCE_EN
      phase_cnt <= 8'd0;
      tog_cnt   <= 8'd0;
`endif
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          contact <= 1'b0;
          if (press_valid) begin
            if (key_ok) begin
              key_r    <= key_rc[3:2];
              key_c    <= key_rc[1:0];
              // A zero hold still produces one clean closed cycle.
              hold_len <= (press_hold == 16'd0) ? 16'd1 : press_hold;
              hold_cnt <= 16'd0;
              contact  <= 1'b1;
`ifdef KPAD_EMU_BOUNCE_EN
              state     <= BOUNCE_IN;
              phase_cnt <= 8'd0;
              tog_cnt   <= 8'd0;
`else
              state     <= HELD;
`endif
            end else begin
              err <= 1'b1;
            end
          end
        end

`ifdef KPAD_EMU_BOUNCE_EN
        BOUNCE_IN: begin
          if (press_abort) begin
            state     <= BOUNCE_OUT;
            contact   <= 1'b0;
            phase_cnt <= 8'd0;
            tog_cnt   <= 8'd0;
          end else if (phase_end) begin
            state    <= HELD;
            contact  <= 1'b1;
            hold_cnt <= 16'd0;
          end else begin
            phase_cnt <= phase_cnt + 8'd1;
            if (tog_end) begin
              tog_cnt <= 8'd0;
              contact <= ~contact;
            end else begin
              tog_cnt <= tog_cnt + 8'd1;
            end
          end
        end
`endif

        HELD: begin
          if (press_abort || hold_end) begin
            hold_cnt <= 16'd0;
            contact  <= 1'b0;
`ifdef KPAD_EMU_BOUNCE_EN
            state     <= BOUNCE_OUT;
            phase_cnt <= 8'd0;
            tog_cnt   <= 8'd0;
`else
            state     <= IDLE;
            done      <= 1'b1;
`endif
          end else begin
            // hold_cnt stops at hold_len-1 <= 65534, so it never wraps.
            hold_cnt <= hold_cnt + 16'd1;
          end
        end

`ifdef KPAD_EMU_BOUNCE_EN
        BOUNCE_OUT: begin
          if (phase_end) begin
            state     <= IDLE;
            contact   <= 1'b0;
            done      <= 1'b1;
            phase_cnt <= 8'd0;
            tog_cnt   <= 8'd0;
          end else begin
            phase_cnt <= phase_cnt + 8'd1;
            if (tog_end) begin
              tog_cnt <= 8'd0;
              contact <= ~contact;
            end else begin
              tog_cnt <= tog_cnt + 8'd1;
            end
          end
        end
`endif

        default: begin
          state   <= IDLE;
          contact <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_matrix_emu.sv
// tb_keypad_matrix_emu: directed bench for keypad_matrix_emu. Expected
// {key, done, busy, ready, contact} per cycle are queued from the press
// timeline and compared cycle by cycle; row is checked against the matrix rule.
module tb_keypad_matrix_emu;

  localparam int BC = 16;
  localparam int BT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  column;
  logic [2:0]  row;
  logic        press_valid;
  logic        press_ready;
  logic [3:0]  press_key;
  logic [15:0] press_hold;
  logic        press_abort;
  logic        contact;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  state_dbg;

  int n_vec = 0;
  int n_err = 0;

  // Scoreboard entries: {key[3:0], done, busy, ready, contact}.
  logic [7:0] exp_q[$];

  logic [2:0] col_seq [5] = '{3'b110, 3'b101, 3'b011, 3'b000, 3'b010};

`ifdef KPAD_EMU_BOUNCE_EN
  localparam int HS = BC;
`else
  localparam int HS = 0;
`endif

  keypad_matrix_emu #(
    .BOUNCE_CYCLES(BC),
    .BOUNCE_TOGGLE(BT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .column      (column),
    .row         (row),
    .press_valid (press_valid),
    .press_ready (press_ready),
    .press_key   (press_key),
    .press_hold  (press_hold),
    .press_abort (press_abort),
    .contact     (contact),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .state_dbg   (state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] ent(input logic [3:0] key, input logic d,
                                     input logic b, input logic c);
    return {key, d, b, ~b, c};
  endfunction

  // Matrix rule: row r of key k=3r+c is low iff contact and column c driven low.
  function automatic logic [2:0] exp_row(input logic [3:0] key, input logic c,
                                         input logic [2:0] col);
    logic [1:0] r;
    logic [1:0] cc;
    logic [2:0] v;
    r  = 2'(key / 4'd3);
    cc = 2'(key % 4'd3);
    v  = 3'b111;
    if (c && col[cc] == 1'b0) v[r] = 1'b0;
    return v;
  endfunction

  // Queue the cycle-by-cycle outcome of one accepted valid press, ending with
  // the done cycle.
  task automatic push_press(input logic [3:0] key, input int hold, input int abort_at);
    int held;
    held = (hold == 0) ? 1 : hold;
    if (abort_at > 0 && abort_at < held) held = abort_at;
`ifdef KPAD_EMU_BOUNCE_EN
    for (int i = 0; i < BC; i++) exp_q.push_back(ent(key, 1'b0, 1'b1, ((i / BT) % 2) == 0));
`endif
    for (int i = 0; i < held; i++) exp_q.push_back(ent(key, 1'b0, 1'b1, 1'b1));
`ifdef KPAD_EMU_BOUNCE_EN
    for (int i = 0; i < BC; i++) exp_q.push_back(ent(key, 1'b0, 1'b1, ((i / BT) % 2) == 1));
`endif
    exp_q.push_back(ent(key, 1'b1, 1'b0, 1'b0));
  endtask

  task automatic start(input logic [3:0] key, input logic [15:0] hold);
    press_key   = key;
    press_hold  = hold;
    press_valid = 1'b1;
    tick;
    press_valid = 1'b0;
  endtask

  // Walk the expected queue one cycle at a time while rotating the column
  // drive; raise abort on sample abort_idx, drop press_valid after release_idx.
  task automatic drain(input int abort_idx, input int release_idx);
    int idx;
    logic [7:0] e;
    idx = 0;
    while (exp_q.size() > 0) begin
      column = col_seq[3'(idx % 5)];
      #1;
      e = exp_q.pop_front();
      chk("flags", {12'd0, done, busy, press_ready, contact}, {12'd0, e[3:0]});
      chk("row", {13'd0, row}, {13'd0, exp_row(e[7:4], e[0], column)});
      press_abort = (idx == abort_idx);
      tick;
      if (idx == release_idx) press_valid = 1'b0;
      idx++;
    end
    press_abort = 1'b0;
  endtask

  initial begin
    int first_done;
    logic done_seen;

    // Reset
    reset       = 1'b1;
    column      = 3'b111;
    press_valid = 1'b0;
    press_key   = 4'd0;
    press_hold  = 16'd0;
    press_abort = 1'b0;
    #3;
    chk("rst_row", {13'd0, row}, 16'h0007);
    chk("rst_ready", {15'd0, press_ready}, 16'd1);
    chk("rst_contact", {15'd0, contact}, 16'd0);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_done_err", {14'd0, done, err}, 16'd0);
    chk("rst_state", {14'd0, state_dbg}, 16'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    tick;

    // Idle matrix: driving a column pulls no row.
    column = 3'b110;
    #1;
    chk("idle_row", {13'd0, row}, 16'h0007);
    chk("idle_ready", {15'd0, press_ready}, 16'd1);
    chk("idle_contact", {15'd0, contact}, 16'd0);

    // Invalid key 11: one err pulse, no press.
    column = 3'b000;
    start(4'd11, 16'd5);
    chk("inv_err", {15'd0, err}, 16'd1);
    chk("inv_busy", {15'd0, busy}, 16'd0);
    chk("inv_row", {13'd0, row}, 16'h0007);
    tick;
    chk("inv_err_clr", {14'd0, err, busy}, 16'd0);
    chk("inv_contact", {15'd0, contact}, 16'd0);

    // Abort while idle is ignored.
    press_abort = 1'b1;
    tick;
    tick;
    press_abort = 1'b0;
    chk("idle_abort", {14'd0, busy, contact}, 16'd0);

    // Key 4 hold 10.
    start(4'd4, 16'd10);
    push_press(4'd4, 10, 0);
    exp_q.push_back(ent(4'd4, 1'b0, 1'b0, 1'b0));
    drain(-1, -1);

    // Key 0 hold 5: contact closed for exactly 5 held cycles.
    start(4'd0, 16'd5);
    push_press(4'd0, 5, 0);
    exp_q.push_back(ent(4'd0, 1'b0, 1'b0, 1'b0));
    drain(-1, -1);

    // Key 7 hold 0 behaves as hold 1.
    start(4'd7, 16'd0);
    push_press(4'd7, 0, 0);
    exp_q.push_back(ent(4'd7, 1'b0, 1'b0, 1'b0));
    drain(-1, -1);

    // Key 8 hold 1000, abort in held cycle 5.
    start(4'd8, 16'd1000);
    push_press(4'd8, 1000, 5);
    exp_q.push_back(ent(4'd8, 1'b0, 1'b0, 1'b0));
    drain(HS + 4, -1);

    // Back-to-back: key 0 hold 3 then key 2 hold 3 with press_valid held.
    press_key   = 4'd0;
    press_hold  = 16'd3;
    press_valid = 1'b1;
    tick;
    press_key = 4'd2;
    push_press(4'd0, 3, 0);
    first_done = exp_q.size() - 1;
    push_press(4'd2, 3, 0);
    exp_q.push_back(ent(4'd2, 1'b0, 1'b0, 1'b0));
    drain(-1, first_done);
    press_valid = 1'b0;

    // Reset in the middle of HELD.
    start(4'd4, 16'd1000);
    repeat (HS + 2) tick;
    column = 3'b000;
    #1;
    chk("mid_contact", {15'd0, contact}, 16'd1);
    chk("mid_row", {13'd0, row}, 16'h0005);
    #1;
    reset = 1'b1;
    #1;
    chk("arst_contact", {15'd0, contact}, 16'd0);
    chk("arst_row", {13'd0, row}, 16'h0007);
    chk("arst_flags", {13'd0, busy, press_ready, done}, 16'h0002);
    chk("arst_state", {14'd0, state_dbg}, 16'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    done_seen = 1'b0;
    for (int i = 0; i < 2 * BC + 20; i++) begin
      tick;
      if (done || busy || contact) done_seen = 1'b1;
    end
    chk("arst_no_done", {15'd0, done_seen}, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
